// File: rtl/ser_tx.sv
// Parallel-to-serial transmitter: latches a PA-bit word and shifts it out one bit per
// ser_valid/ser_ready handshake, with zero-bubble reload on the last bit.
module ser_tx #(
    parameter int PA        = 3,
    parameter int LSB_FIRST = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PA-1:0] in_data,
    output logic          ser_out,
    output logic          ser_valid,
    output logic          ser_last,
    input  logic          ser_ready
);

    localparam int CW = (PA > 1) ? $clog2(PA) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(PA - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PA-1:0] r_shift;
    logic [PA-1:0] w_shift_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_last;
    logic          w_load;
    logic          w_xfer;
    logic          w_out_bit;

    assign w_out_bit = (LSB_FIRST != 0) ? r_shift[0] : r_shift[PA-1];
    assign w_last    = (r_state == SHIFT) && (r_cnt == LAST_IDX);

    assign ser_valid = (r_state == SHIFT);
    assign ser_last  = w_last;
    assign ser_out   = (r_state == SHIFT) ? w_out_bit : 1'b0;
    // A new word can only enter as the final bit of the current one leaves.
    assign in_ready  = (r_state == IDLE) || (w_last && ser_ready);

    assign w_load = in_valid && in_ready;
    assign w_xfer = ser_valid && ser_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_shift_nxt = in_data;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_xfer) begin
                    if (!w_last) begin
                        w_shift_nxt = (LSB_FIRST != 0) ? (r_shift >> 1) : (r_shift << 1);
                        w_cnt_nxt   = r_cnt + CW'(1);
                    end else if (w_load) begin
                        w_shift_nxt = in_data;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ser_tx.sv
// Directed bench for ser_tx: four instances cover PA=3 LSB-first, PA=5 LSB-first,
// PA=5 MSB-first and PA=1, sharing one clock and reset.
module tb_ser_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       a_iv, a_ir, a_so, a_sv, a_sl, a_sr;
    logic [2:0] a_d;
    logic       b_iv, b_ir, b_so, b_sv, b_sl, b_sr;
    logic [4:0] b_d;
    logic       c_iv, c_ir, c_so, c_sv, c_sl, c_sr;
    logic [4:0] c_d;
    logic       d_iv, d_ir, d_so, d_sv, d_sl, d_sr;
    logic [0:0] d_d;

    ser_tx #(.PA(3), .LSB_FIRST(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_d),
        .ser_out(a_so), .ser_valid(a_sv), .ser_last(a_sl), .ser_ready(a_sr));
    ser_tx #(.PA(5), .LSB_FIRST(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_d),
        .ser_out(b_so), .ser_valid(b_sv), .ser_last(b_sl), .ser_ready(b_sr));
    ser_tx #(.PA(5), .LSB_FIRST(0)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_d),
        .ser_out(c_so), .ser_valid(c_sv), .ser_last(c_sl), .ser_ready(c_sr));
    ser_tx #(.PA(1), .LSB_FIRST(1)) u_d (
        .clk(clk), .rst(rst), .in_valid(d_iv), .in_ready(d_ir), .in_data(d_d),
        .ser_out(d_so), .ser_valid(d_sv), .ser_last(d_sl), .ser_ready(d_sr));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic probe(input int k, output logic v, output logic o,
                         output logic l, output logic r);
        case (k)
            0:       begin v = a_sv; o = a_so; l = a_sl; r = a_ir; end
            1:       begin v = b_sv; o = b_so; l = b_sl; r = b_ir; end
            2:       begin v = c_sv; o = c_so; l = c_sl; r = c_ir; end
            default: begin v = d_sv; o = d_so; l = d_sl; r = d_ir; end
        endcase
    endtask

    // Sample at the falling edge, then advance to just after the next rising edge.
    task automatic cyc(input int k, input string tag, input logic ev, input logic eo,
                       input logic el, input logic er);
        logic v, o, l, r;
        @(negedge clk);
        probe(k, v, o, l, r);
        check({tag, ".valid"}, v, ev);
        check({tag, ".ready"}, r, er);
        check({tag, ".last"}, l, el);
        if (ev) check({tag, ".out"}, o, eo);
        @(posedge clk);
        #1;
    endtask

    logic [4:0] msb_word;

    initial begin
        logic v, o, l, r;
        rst  = 1'b1;
        a_iv = 1'b0; a_d = '0; a_sr = 1'b0;
        b_iv = 1'b0; b_d = '0; b_sr = 1'b0;
        c_iv = 1'b0; c_d = '0; c_sr = 1'b0;
        d_iv = 1'b0; d_d = '0; d_sr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            probe(k, v, o, l, r);
            check("rst.valid", v, 1'b0);
            check("rst.out", o, 1'b0);
            check("rst.last", l, 1'b0);
            check("rst.ready", r, 1'b1);
        end
        rst = 1'b0;

        // Basic word 3'b101, LSB first
        a_sr = 1'b1; a_iv = 1'b1; a_d = 3'b101;
        cyc(0, "basic_idle", 0, 0, 0, 1);
        a_iv = 1'b0;
        cyc(0, "basic_b0", 1, 1, 0, 0);
        cyc(0, "basic_b1", 1, 0, 0, 0);
        cyc(0, "basic_b2", 1, 1, 1, 1);
        cyc(0, "basic_end", 0, 0, 0, 1);

        // Backpressure on first bit of 3'b110
        a_iv = 1'b1; a_d = 3'b110;
        cyc(0, "bp_idle", 0, 0, 0, 1);
        a_iv = 1'b0; a_sr = 1'b0;
        for (int i = 0; i < 4; i++) cyc(0, "bp_hold", 1, 0, 0, 0);
        a_sr = 1'b1;
        cyc(0, "bp_b0", 1, 0, 0, 0);
        cyc(0, "bp_b1", 1, 1, 0, 0);
        cyc(0, "bp_b2", 1, 1, 1, 1);
        cyc(0, "bp_end", 0, 0, 0, 1);

        // Back-to-back 3'b001 then 3'b010; in_data changes while not ready
        a_iv = 1'b1; a_d = 3'b001;
        cyc(0, "b2b_idle", 0, 0, 0, 1);
        a_d = 3'b010;
        cyc(0, "b2b_w0b0", 1, 1, 0, 0);
        cyc(0, "b2b_w0b1", 1, 0, 0, 0);
        cyc(0, "b2b_w0b2", 1, 0, 1, 1);
        a_iv = 1'b0;
        cyc(0, "b2b_w1b0", 1, 0, 0, 0);
        cyc(0, "b2b_w1b1", 1, 1, 0, 0);
        cyc(0, "b2b_w1b2", 1, 0, 1, 1);
        cyc(0, "b2b_end", 0, 0, 0, 1);

        // Asynchronous reset mid-word, then reload of zeros
        b_sr = 1'b1; b_iv = 1'b1; b_d = 5'h1F;
        cyc(1, "rm_idle", 0, 0, 0, 1);
        b_iv = 1'b0;
        cyc(1, "rm_b0", 1, 1, 0, 0);
        cyc(1, "rm_b1", 1, 1, 0, 0);
        #1 rst = 1'b1;
        #1;
        probe(1, v, o, l, r);
        check("rm_async.valid", v, 1'b0);
        check("rm_async.out", o, 1'b0);
        check("rm_async.last", l, 1'b0);
        check("rm_async.ready", r, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0; b_iv = 1'b1; b_d = 5'h00;
        cyc(1, "rm_idle2", 0, 0, 0, 1);
        b_iv = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1, "rm_zero", 1, 0, 0, 0);
        cyc(1, "rm_zero_last", 1, 0, 1, 1);
        cyc(1, "rm_end", 0, 0, 0, 1);

        // MSB first 5'b10011
        msb_word = 5'b10011;
        c_sr = 1'b1; c_iv = 1'b1; c_d = msb_word;
        cyc(2, "msb_idle", 0, 0, 0, 1);
        c_iv = 1'b0;
        for (int i = 0; i < 5; i++) cyc(2, "msb_bit", 1, msb_word[4-i], i == 4, i == 4);
        cyc(2, "msb_end", 0, 0, 0, 1);

        // Single-bit words 1,0,1 streamed back to back
        d_sr = 1'b1; d_iv = 1'b1; d_d = 1'b1;
        cyc(3, "sb_idle", 0, 0, 0, 1);
        d_d = 1'b0;
        cyc(3, "sb_w0", 1, 1, 1, 1);
        d_d = 1'b1;
        cyc(3, "sb_w1", 1, 0, 1, 1);
        d_iv = 1'b0;
        cyc(3, "sb_w2", 1, 1, 1, 1);
        cyc(3, "sb_end", 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ser_tx.md
SER_TX -- requirements
Module: ser_tx

Interface
REQ-001 SHALL have parameter PA, default 3, meaning word width in bits; legal range is 1 or more.
REQ-002 SHALL have parameter LSB_FIRST, default 1, meaning bit order: 1 sends bit 0 first, 0 sends bit PA-1 first.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  meaning reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  meaning a parallel word is offered on in_data.
REQ-006 SHALL have port in_ready  output  1  meaning the block accepts in_data this cycle.
REQ-007 SHALL have port in_data  input  PA  meaning the parallel word to serialize.
REQ-008 SHALL have port ser_out  output  1  meaning the current serial bit.
REQ-009 SHALL have port ser_valid  output  1  meaning ser_out holds a valid bit.
REQ-010 SHALL have port ser_last  output  1  meaning ser_out is the final bit of the word.
REQ-011 SHALL have port ser_ready  input  1  meaning the sink consumes the bit this cycle.

Function
REQ-012 SHALL implement two states: IDLE and SHIFT.
REQ-013 SHALL hold an internal PA-bit shift register and a bit counter.
  - Counter width is max(1, clog2(PA)).
REQ-014 SHALL define a load event as in_valid && in_ready at the posedge.
REQ-015 SHALL define a bit transfer as ser_valid && ser_ready at the posedge.
REQ-016 In IDLE, SHALL drive in_ready=1, ser_valid=0 and ser_last=0.
REQ-017 On a load in IDLE, SHALL latch in_data, clear the counter and enter SHIFT.
  - The first bit appears on ser_out with ser_valid=1 in the next cycle (latency 1 clock).
REQ-018 In SHIFT, SHALL drive ser_valid=1.
  - ser_out = shift-register bit 0 when LSB_FIRST=1; bit PA-1 when LSB_FIRST=0.
REQ-019 In SHIFT, SHALL drive ser_last=1 exactly when the counter equals PA-1.
REQ-020 In SHIFT without a bit transfer, SHALL hold ser_out, ser_last, the counter and the shift register unchanged.
  - This is backpressure with no bit loss.
REQ-021 On a bit transfer with ser_last=0, SHALL shift the register one position toward the output end and increment the counter.
REQ-022 In SHIFT, SHALL drive in_ready = ser_last && ser_ready (combinational), and 0 otherwise.
REQ-023 On a bit transfer with ser_last=1 and a simultaneous load, SHALL latch the new word, clear the counter and stay in SHIFT.
  - Zero-bubble back-to-back words.
REQ-024 On a bit transfer with ser_last=1 and no load, SHALL return to IDLE.
  - ser_valid=0 in the next cycle.
REQ-025 SHALL ignore in_data whenever no load occurs.
  - SHALL not alter the in-flight word when in_valid is high while in_ready=0.
REQ-026 For PA=1, SHALL hold ser_last=1 throughout SHIFT.
  - Each word takes one bit transfer.
REQ-027 SHALL deliver exactly PA bit transfers per loaded word, in the order set by LSB_FIRST.

Reset
REQ-028 While rst=1, SHALL force state to IDLE and clear the shift register and counter.
  - Outputs while in reset: ser_out=0, ser_valid=0, ser_last=0, in_ready=1.
REQ-029 Reset asserted mid-word SHALL discard the remaining bits immediately, without waiting for clk.
REQ-030 After rst deasserts, SHALL accept a load on the first posedge with in_valid=1.

Verification
REQ-031 Basic word: PA=3, LSB_FIRST=1, ser_ready=1, load 3'b101 -> ser_out 1,0,1 on three consecutive cycles, ser_last only on the third; ser_valid low afterwards.
REQ-032 Backpressure: PA=3, load 3'b110, ser_ready=0 for 4 cycles after the first bit -> ser_out held at 0 with ser_valid=1; then the sequence resumes 0,1,1 with no loss.
REQ-033 Back-to-back: PA=3, in_valid held high with 3'b001 then 3'b010 -> stream 1,0,0,0,1,0 with no gap cycle; in_ready pulses in the last-bit cycle of the first word.
REQ-034 Reset mid-word: PA=5, load 5'h1F, assert rst after 2 bits -> ser_valid=0 immediately; a new load of 5'h00 yields five 0 bits.
REQ-035 MSB-first: PA=5, LSB_FIRST=0, load 5'b10011 -> ser_out 1,0,0,1,1 with ser_last on the fifth bit.
REQ-036 Single bit: PA=1, three consecutive loads 1,0,1 with ser_ready=1 -> ser_out 1,0,1 with ser_last=1 on every valid cycle.
